// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: synchronises/debounces start-stop and lap buttons,
// turns presses into events and sequences run / clr / hold / lap_cnt.
// Ports: clk, rst (async, active-high); btn_ss, btn_lap raw buttons;
//        run, clr, hold, state_o[1:0], lap_cnt[3:0] registered outputs.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYC  = 1000000,
  parameter int LONGPRESS_CYC = 100000000,
  parameter int LAP_MAX       = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic       run,
  output logic       clr,
  output logic       hold,
  output logic [1:0] state_o,
  output logic [3:0] lap_cnt
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HW = (LONGPRESS_CYC > 1) ? $clog2(LONGPRESS_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // Bit 0 = start/stop, bit 1 = lap.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_prev_q;
  logic [DW-1:0] dcnt_q [2];
  logic [HW-1:0] hcnt_q;

  state_t        state_q, state_d;
  logic          clr_q, clr_d;
  logic          run_q, run_d;
  logic          hold_q, hold_d;
  logic [3:0]    lap_q, lap_d;

  logic [1:0]    press;
  logic          ss_ev, lap_ev, long_ev;

  // Synchronisers and per-button debounce counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q    <= {btn_lap, btn_ss};
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
          deb_q[i]  <= ~deb_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Press events are combinational off the debounced edge so the FSM
  // reacts on the very next edge after the debounced level flips.
  assign press  = deb_q & ~deb_prev_q;
  assign ss_ev  = press[0];
  assign lap_ev = press[1] & ~press[0];

  // Hold counter parks at LONGPRESS_CYC-1; the step into that value is the
  // one and only long-press event for this hold.
  assign long_ev = deb_q[1] && (hcnt_q == HW'(LONGPRESS_CYC - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
    end else if (!deb_q[1]) begin
      hcnt_q <= '0;
    end else if (hcnt_q != HW'(LONGPRESS_CYC - 1)) begin
      hcnt_q <= hcnt_q + 1'b1;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
      run_q   <= 1'b0;
      hold_q  <= 1'b0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
      lap_q   <= lap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    lap_d   = lap_q;
    if (long_ev) begin
      state_d = IDLE;
      clr_d   = 1'b1;
      lap_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_ev) state_d = RUN;
        end
        RUN: begin
          if (ss_ev) begin
            state_d = PAUSE;
          end else if (lap_ev) begin
            state_d = LAP;
            if (lap_q != 4'(LAP_MAX)) lap_d = lap_q + 4'd1;
          end
        end
        LAP: begin
          if (ss_ev)       state_d = PAUSE;
          else if (lap_ev) state_d = RUN;
        end
        PAUSE: begin
          if (ss_ev) begin
            state_d = RUN;
          end else if (lap_ev) begin
            state_d = IDLE;
            clr_d   = 1'b1;
            lap_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    run_d  = (state_d == RUN) || (state_d == LAP);
    hold_d = (state_d == LAP);
  end

  assign run     = run_q;
  assign clr     = clr_q;
  assign hold    = hold_q;
  assign state_o = state_q;
  assign lap_cnt = lap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with short debounce/long-press parameters.
// Table of button pulses with hand-computed end states, plus hand-written
// sequences for latency, long press, lap saturation and mid-debounce reset.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_lap = 1'b0;
  logic       run, clr, hold;
  logic [1:0] state_o;
  logic [3:0] lap_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int clr_cnt = 0;
  int clr_consec = 0;
  logic clr_prev = 1'b0;

  stopwatch_ctrl #(
    .DEBOUNCE_CYC (4),
    .LONGPRESS_CYC(20),
    .LAP_MAX      (15)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_ss (btn_ss),
    .btn_lap(btn_lap),
    .run    (run),
    .clr    (clr),
    .hold   (hold),
    .state_o(state_o),
    .lap_cnt(lap_cnt)
  );

  always #5 clk = ~clk;

  // clr pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr === 1'b1) clr_cnt = clr_cnt + 1;
    if (clr === 1'b1 && clr_prev === 1'b1) clr_consec = clr_consec + 1;
    clr_prev = clr;
  end

  typedef struct {
    logic       ss;
    logic       lap;
    int         hi;
    logic [1:0] st;
    logic       rn;
    logic       hd;
    logic [3:0] lc;
    int         clrs;
  } vec_t;

  vec_t vt [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    int c0;
    c0 = clr_cnt;
    btn_ss  = v.ss;
    btn_lap = v.lap;
    repeat (v.hi) tick();
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (12) tick();
    chk($sformatf("v%0d_state", idx), 32'(state_o), 32'(v.st));
    chk($sformatf("v%0d_run", idx),   32'(run),     32'(v.rn));
    chk($sformatf("v%0d_hold", idx),  32'(hold),    32'(v.hd));
    chk($sformatf("v%0d_lap", idx),   32'(lap_cnt), 32'(v.lc));
    chk($sformatf("v%0d_clrs", idx),  32'(clr_cnt - c0), 32'(v.clrs));
  endtask

  initial begin
    int c0;
    vec_t v;

    //            ss    lap   hi  st    rn    hd    lc     clrs
    vt[0]  = '{1'b0, 1'b1, 10, 2'd3, 1'b1, 1'b1, 4'd1, 0}; // RUN lap -> LAP
    vt[1]  = '{1'b0, 1'b1, 10, 2'd1, 1'b1, 1'b0, 4'd1, 0}; // LAP lap -> RUN
    vt[2]  = '{1'b1, 1'b0, 10, 2'd2, 1'b0, 1'b0, 4'd1, 0}; // RUN ss -> PAUSE
    vt[3]  = '{1'b0, 1'b1, 10, 2'd0, 1'b0, 1'b0, 4'd0, 1}; // PAUSE lap -> IDLE, clr
    vt[4]  = '{1'b1, 1'b0, 1,  2'd0, 1'b0, 1'b0, 4'd0, 0}; // 1-cycle glitch
    vt[5]  = '{1'b1, 1'b0, 2,  2'd0, 1'b0, 1'b0, 4'd0, 0}; // 2-cycle glitch
    vt[6]  = '{1'b1, 1'b0, 3,  2'd0, 1'b0, 1'b0, 4'd0, 0}; // 3-cycle glitch
    vt[7]  = '{1'b0, 1'b1, 10, 2'd0, 1'b0, 1'b0, 4'd0, 0}; // lap ignored in IDLE
    vt[8]  = '{1'b1, 1'b0, 10, 2'd1, 1'b1, 1'b0, 4'd0, 0}; // IDLE ss -> RUN
    vt[9]  = '{1'b0, 1'b1, 10, 2'd3, 1'b1, 1'b1, 4'd1, 0}; // RUN lap -> LAP
    vt[10] = '{1'b0, 1'b1, 10, 2'd1, 1'b1, 1'b0, 4'd1, 0}; // LAP lap -> RUN
    vt[11] = '{1'b1, 1'b1, 10, 2'd2, 1'b0, 1'b0, 4'd1, 0}; // both: ss wins -> PAUSE
    vt[12] = '{1'b1, 1'b0, 10, 2'd1, 1'b1, 1'b0, 4'd1, 0}; // PAUSE ss -> RUN

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_run",   32'(run),     32'd0);
    chk("rst_clr",   32'(clr),     32'd0);
    chk("rst_hold",  32'(hold),    32'd0);
    chk("rst_lap",   32'(lap_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // First-press latency: DEBOUNCE_CYC+3 = 7 edges.
    btn_ss = 1'b1;
    repeat (6) tick();
    chk("lat_state_e6", 32'(state_o), 32'd0);
    tick();
    chk("lat_state_e7", 32'(state_o), 32'd1);
    chk("lat_run_e7",   32'(run),     32'd1);
    repeat (3) tick();
    btn_ss = 1'b0;
    repeat (12) tick();
    chk("lat_no_clr", 32'(clr_cnt), 32'd0);

    for (int i = 0; i < 13; i++) apply(vt[i], i);

    // Long press from RUN: enters LAP first, then clears once.
    c0 = clr_cnt;
    btn_lap = 1'b1;
    repeat (15) tick();
    chk("lp_mid_state", 32'(state_o), 32'd3);
    chk("lp_mid_hold",  32'(hold),    32'd1);
    chk("lp_mid_lap",   32'(lap_cnt), 32'd2);
    repeat (25) tick();
    chk("lp_end_state", 32'(state_o), 32'd0);
    chk("lp_end_run",   32'(run),     32'd0);
    chk("lp_end_hold",  32'(hold),    32'd0);
    chk("lp_end_lap",   32'(lap_cnt), 32'd0);
    chk("lp_held_clrs", 32'(clr_cnt - c0), 32'd1);
    btn_lap = 1'b0;
    repeat (12) tick();
    chk("lp_rel_clrs",  32'(clr_cnt - c0), 32'd1);
    chk("lp_rel_state", 32'(state_o), 32'd0);

    // Back to RUN, then 16 laps: lap_cnt saturates at 15.
    v = '{1'b1, 1'b0, 10, 2'd1, 1'b1, 1'b0, 4'd0, 0};
    apply(v, 100);
    for (int i = 0; i < 16; i++) begin
      v = '{1'b0, 1'b1, 10, 2'd3, 1'b1, 1'b1, 4'((i + 1 > 15) ? 15 : i + 1), 0};
      apply(v, 200 + 2 * i);
      v = '{1'b0, 1'b1, 10, 2'd1, 1'b1, 1'b0, 4'((i + 1 > 15) ? 15 : i + 1), 0};
      apply(v, 201 + 2 * i);
    end

    // Reset mid-debounce, button kept held through and after reset.
    c0 = clr_cnt;
    btn_ss = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("mrst_state", 32'(state_o), 32'd0);
    chk("mrst_run",   32'(run),     32'd0);
    chk("mrst_lap",   32'(lap_cnt), 32'd0);
    tick();
    chk("mrst_clr",   32'(clr),     32'd0);
    chk("mrst_hold",  32'(hold),    32'd0);
    rst = 1'b0;
    repeat (6) tick();
    chk("mrst_redeb_e6", 32'(state_o), 32'd0);
    tick();
    chk("mrst_redeb_e7", 32'(state_o), 32'd1);
    btn_ss = 1'b0;
    repeat (12) tick();
    chk("mrst_no_clr", 32'(clr_cnt - c0), 32'd0);

    chk("clr_consec", 32'(clr_consec), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the mm:ss stopwatch counter from two raw push-buttons (start/stop and lap/clear). It synchronises and debounces both buttons and turns presses into single events. It drives the counter's run enable, a one-cycle soft-clear pulse, and a display-hold flag that freezes the 7-segment digits during a lap. It sits between the board buttons and the counter/display datapath, all in the 50 MHz clk domain.

Parameters:
DEBOUNCE_CYC, 1000000, consecutive stable cycles required before a debounced level changes (20 ms at 50 MHz)
LONGPRESS_CYC, 100000000, cycles the debounced lap button must stay high to trigger a long-press clear (2 s)
LAP_MAX, 15, saturation value of lap_cnt (must be ≤ 15)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
btn_ss  input  1  raw start/stop button, active-high, asynchronous to clk
btn_lap  input  1  raw lap/clear button, active-high, asynchronous to clk
run  output  1  counter enable; high in RUN and LAP
clr  output  1  one-cycle soft-clear pulse to the counter
hold  output  1  display freeze; high only in LAP
state_o  output  2  current state: IDLE=0, RUN=1, PAUSE=2, LAP=3
lap_cnt  output  4  number of laps taken since the last clear; saturates at LAP_MAX

Behaviour:
- Reset is clock rst, asynchronous, active-high. On reset: state IDLE, run=0, clr=0, hold=0, lap_cnt=0, synchronisers=0, debounced levels=0, all counters=0. rst does not generate a clr pulse.
- Synchronisation: each button passes through a 2-FF synchroniser.
- Debounce, per button:
  - The stability counter resets to 0 on any cycle where the synchronised level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYC-1, the debounced level flips on that edge and the counter resets.
  - A glitch shorter than DEBOUNCE_CYC cycles has no effect.
- Press event: a one-cycle internal pulse on each 0→1 transition of a debounced level. Release produces no event.
- Latency: state and registered outputs update exactly DEBOUNCE_CYC+3 edges after the first edge that samples the new raw level.
- Long press:
  - The lap hold counter increments while debounced lap=1 and resets when it is 0.
  - Reaching LONGPRESS_CYC-1 fires one long-press event.
  - Only one event fires per hold; the counter then stops until release.
- Transitions (registered; run, hold and state_o derive from the next state, so they change on the same edge as the state):
  - IDLE: ss → RUN. Lap press is ignored.
  - RUN: ss → PAUSE. Lap press → LAP, and lap_cnt increments (saturating at LAP_MAX).
  - LAP: lap press → RUN (hold drops). ss → PAUSE (hold drops).
  - PAUSE: ss → RUN. Lap press → IDLE with clr=1 for one cycle and lap_cnt=0.
  - Any state, long-press event: → IDLE with clr=1 for one cycle and lap_cnt=0. This overrides any same-cycle press event.
- Simultaneous ss and lap press events in the same cycle: ss takes priority and the lap event is dropped.
- A lap press in RUN that becomes a long press first enters LAP (lap_cnt+1), then clears to IDLE at the long-press event.
- clr is only ever a single-cycle pulse, never two consecutive cycles.
- Counter widths are derived with $clog2 of the parameters. No wrap is allowed: the stability counter is bounded by DEBOUNCE_CYC and the hold counter stops at LONGPRESS_CYC-1.
- Reset mid-debounce or mid-hold: all progress is discarded. A button still held after rst releases must be re-debounced, and it generates a press event once its debounced level rises.

Test Plan (DEBOUNCE_CYC=4, LONGPRESS_CYC=20, LAP_MAX=15):
- Reset, then btn_ss high for 10 cycles → state_o 0→1 exactly 7 edges after first sample, run=1, clr never asserted.
- RUN, btn_lap pulse 10 cycles → state_o=3, hold=1, run=1, lap_cnt=1; second lap press → state_o=1, hold=0, lap_cnt=1.
- RUN, btn_ss press → PAUSE, run=0; then lap press → clr high exactly 1 cycle, lap_cnt=0, state_o=0.
- Glitches on btn_ss of 1, 2 and 3 cycles separated by ≥1 low cycle, in IDLE → state_o stays 0, run stays 0.
- RUN, btn_lap held 40 cycles → LAP (lap_cnt=1) then IDLE with a single clr pulse, lap_cnt=0, no further clr while still held.
- Both buttons rise in the same cycle in RUN → PAUSE, lap_cnt unchanged. 16 laps → lap_cnt saturates at 15. rst asserted mid-debounce → all outputs 0 next cycle with no clr pulse.
